// File: rtl/uart_rx_ext_if.sv
// uart_rx_ext_if: received-word stream with per-frame error flags and overrun pulse
interface uart_rx_ext_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 break_det;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, break_det, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, break_det, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: UART receiver with input sync, majority vote, parity/stop checks and a valid/ready output
module uart_rx_ext #(
    parameter int CLK_FREQ  = 12_000_000,
    parameter int BAUDRATE  = 230_400,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic busy,
    uart_rx_ext_if.master stream
);
    localparam int CPB  = CLK_FREQ / BAUDRATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2((2 + DATA_BITS + STOP_BITS) * CPB);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_nxt;
    logic                 s1, s2, armed, vote, smp, done, ferr, perr;
    logic                 shift, chk_par, chk_stop, last;
    logic [2:0]           hist;
    logic [CW-1:0]        cnt, target;
    logic [3:0]           bits;
    logic [DATA_BITS-1:0] data;

    assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    assign smp  = cnt == target;

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // Next state: start only after the line was seen high again, so a held-low line is one break
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (armed && !s2) state_nxt = START;
            START:   if (smp) state_nxt = vote ? IDLE : DATA;
            DATA:    if (smp && bits == 4'(DATA_BITS - 1)) state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:     if (smp) state_nxt = STOP;
            STOP:    if (smp && bits == 4'(STOP_BITS - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy flag and per-state sample strobes
    always_comb begin
        busy     = state != IDLE;
        shift    = state == DATA && smp;
        chk_par  = state == PAR && smp;
        chk_stop = state == STOP && smp;
        last     = chk_stop && bits == 4'(STOP_BITS - 1);
    end

    // Synchroniser, vote history, bit timing and frame assembly
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            hist   <= 3'b111;
            armed  <= 1'b0;
            cnt    <= '0;
            target <= CW'(HALF);
            bits   <= '0;
            data   <= '0;
            ferr   <= 1'b0;
            perr   <= 1'b0;
            done   <= 1'b0;
        end else begin
            s1     <= rx;
            s2     <= s1;
            hist   <= {hist[1:0], s2};
            armed  <= state == IDLE && (armed || s2);
            cnt    <= busy ? cnt + 1'b1 : '0;
            target <= !busy ? CW'(HALF) : smp ? target + CW'(CPB) : target;
            bits   <= state_nxt != state ? '0 : smp ? bits + 1'b1 : bits;
            done   <= last;
            if (shift) data <= {vote, data[DATA_BITS-1:1]};
            if (state == IDLE && state_nxt == START) begin
                ferr <= 1'b0;
                perr <= 1'b0;
            end
            if (chk_par) perr <= (^data ^ vote) != (PARITY == 1);
            if (chk_stop && !vote) ferr <= 1'b1;
        end

    // Output register: load a finished frame if the slot is free, else keep the old word and flag overrun
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            stream.rx_data    <= '0;
            stream.rx_valid   <= 1'b0;
            stream.frame_err  <= 1'b0;
            stream.parity_err <= 1'b0;
            stream.break_det  <= 1'b0;
            stream.overrun    <= 1'b0;
        end else begin
            stream.overrun <= done && stream.rx_valid && !stream.rx_ready;
            if (done && (!stream.rx_valid || stream.rx_ready)) begin
                stream.rx_data    <= data;
                stream.frame_err  <= ferr;
                stream.parity_err <= perr;
                stream.break_det  <= ferr && data == '0;
                stream.rx_valid   <= 1'b1;
            end else if (stream.rx_valid && stream.rx_ready) begin
                stream.rx_valid <= 1'b0;
            end
        end
endmodule
